// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS datapath: add/sub/and/or/slt, lw, sw, beq, addi, j.
// Define MIPS_CTRL_PERF_EN to add the instr_count / cycle_count performance counters.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memwrite,
    output logic        iord,
    output logic        irwrite,
    output logic        pc_en,
    output logic [1:0]  pcsrc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [3:0]  aluControl,
    output logic        regdst,
    output logic        memtoReg,
    output logic        regWrite,
    output logic        illegal_op,
    output logic        mem_err
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic             TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = (MEM_TIMEOUT != 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    state_e           dec_state;
    logic             dec_ill;
    logic [3:0]       rtype_alu;
    logic             wait_st;
    logic             timeout;

    always_comb begin
        dec_state = S_FETCH;
        dec_ill   = 1'b0;
        case (op)
            6'h00: begin
                if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) dec_state = S_EXEC;
                else dec_ill = 1'b1;
            end
            6'h23, 6'h2B: dec_state = S_MEMADR;
            6'h04:        dec_state = S_BRANCH;
            6'h08:        dec_state = S_ADDIEX;
            6'h02:        dec_state = S_JUMP;
            default:      dec_ill   = 1'b1;
        endcase
    end

    always_comb begin
        case (funct)
            6'h22:   rtype_alu = ALU_SUB;
            6'h24:   rtype_alu = ALU_AND;
            6'h25:   rtype_alu = ALU_OR;
            6'h2A:   rtype_alu = ALU_SLT;
            default: rtype_alu = ALU_ADD;
        endcase
    end

    // abort_q marks the one idle FETCH cycle after a timeout, where the request is dropped
    assign wait_st = !abort_q && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
    assign timeout = TMO_EN && wait_st && !mem_ready && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        if (wait_st && !mem_ready) begin
            if (timeout) begin
                state_d = S_FETCH;
                cnt_d   = '0;
                abort_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
            case (state_q)
                S_FETCH:  if (!abort_q) state_d = S_DECODE;
                S_DECODE: state_d = dec_state;
                S_MEMADR: state_d = (op == 6'h23) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_EXEC:   state_d = S_ALUWB;
                S_ADDIEX: state_d = S_ADDIWB;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pc_en      = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluControl = ALU_AND;
        regdst     = 1'b0;
        memtoReg   = 1'b0;
        regWrite   = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        if (reset) begin
            mem_err = timeout;
            case (state_q)
                S_FETCH: begin
                    if (!abort_q) begin
                        mem_req    = 1'b1;
                        alusrcb    = 2'b01;
                        aluControl = ALU_ADD;
                        irwrite    = mem_ready;
                        pc_en      = mem_ready;
                    end
                end
                S_DECODE: begin
                    alusrcb    = 2'b11;
                    aluControl = ALU_ADD;
                    illegal_op = dec_ill;
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    aluControl = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    memtoReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca    = 1'b1;
                    aluControl = rtype_alu;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca    = 1'b1;
                    aluControl = ALU_SUB;
                    pcsrc      = 2'b01;
                    pc_en      = zero;
                end
                S_ADDIWB: regWrite = 1'b1;
                S_JUMP: begin
                    pcsrc = 2'b10;
                    pc_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] instr_q, cycle_q;
    logic        retire;

    // Any entry into FETCH except from DECODE (illegal op) or a timeout completes an instruction
    assign retire = (state_q != S_FETCH) && (state_q != S_DECODE) && (state_d == S_FETCH) && !timeout;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            abort_q <= 1'b0;
`ifdef MIPS_CTRL_PERF_EN
            instr_q <= '0;
            cycle_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
`ifdef MIPS_CTRL_PERF_EN
            cycle_q <= cycle_q + 32'd1;
            if (retire) instr_q <= instr_q + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus randomized traffic against a
// per-instruction-class step model.
module tb_mips_multicycle_ctrl;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       mem_req, memwrite, iord, irwrite, pc_en, alusrca;
    logic [1:0] pcsrc, alusrcb;
    logic [3:0] aluControl;
    logic       regdst, memtoReg, regWrite, illegal_op, mem_err;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] instr_count, cycle_count;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pc_en(pc_en),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluControl(aluControl),
        .regdst(regdst), .memtoReg(memtoReg), .regWrite(regWrite), .illegal_op(illegal_op),
        .mem_err(mem_err)
`ifdef MIPS_CTRL_PERF_EN
        , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
    );

    typedef struct packed {
        logic       mem_req, memwrite, iord, irwrite, pc_en;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alu;
        logic       regdst, memtoReg, regWrite, illegal_op, mem_err;
    } ctl_t;

    ctl_t obs, exp_v;
    assign obs = {mem_req, memwrite, iord, irwrite, pc_en, pcsrc, alusrca, alusrcb, aluControl,
                  regdst, memtoReg, regWrite, illegal_op, mem_err};

    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

    // Model: phase 0 = fetching, phase k>0 = k-th cycle after fetch for the current class
    int          m_phase = 0, m_cls = C_ILL, m_wait = 0;
    bit          m_drop = 1'b0;
    logic [31:0] m_instr = '0, m_cycles = '0;
    int          n_tests = 0, n_fail = 0;

    function automatic int classify(logic [5:0] o, logic [5:0] f);
        case (o)
            6'h00:   return (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? C_R : C_ILL;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h02:   return C_J;
            default: return C_ILL;
        endcase
    endfunction

    // cycles after fetch: R 3, lw 4, sw 3, beq 2, addi 3, j 2, illegal 1
    function automatic int post_len(int c);
        case (c)
            C_R, C_SW, C_ADDI: return 3;
            C_LW:              return 4;
            C_BEQ, C_J:        return 2;
            default:           return 1;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic [5:0] f);
        case (f)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic bit mem_phase();
        return (m_phase == 0 && !m_drop) || (m_phase == 3 && (m_cls == C_LW || m_cls == C_SW));
    endfunction

    function automatic bit tmo_hit();
        return TMO != 0 && mem_phase() && !mem_ready && m_wait == TMO - 1;
    endfunction

    function automatic ctl_t model_out();
        ctl_t e;
        e = '0;
        if (!reset || (m_phase == 0 && m_drop)) return e;
        e.mem_err = tmo_hit();
        case (m_phase)
            0: begin
                e.mem_req = 1'b1; e.alusrcb = 2'b01; e.alu = 4'b0010;
                e.irwrite = mem_ready; e.pc_en = mem_ready;
            end
            1: begin
                e.alusrcb = 2'b11; e.alu = 4'b0010;
                e.illegal_op = (classify(op, funct) == C_ILL);
            end
            2: case (m_cls)
                C_R:                begin e.alusrca = 1'b1; e.alu = alu_of(funct); end
                C_LW, C_SW, C_ADDI: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alu = 4'b0010; end
                C_BEQ: begin e.alusrca = 1'b1; e.alu = 4'b0110; e.pcsrc = 2'b01; e.pc_en = zero; end
                C_J:   begin e.pcsrc = 2'b10; e.pc_en = 1'b1; end
                default: ;
            endcase
            3: case (m_cls)
                C_R:    begin e.regdst = 1'b1; e.regWrite = 1'b1; end
                C_LW:   begin e.mem_req = 1'b1; e.iord = 1'b1; end
                C_SW:   begin e.mem_req = 1'b1; e.memwrite = 1'b1; e.iord = 1'b1; end
                C_ADDI: e.regWrite = 1'b1;
                default: ;
            endcase
            4: if (m_cls == C_LW) begin e.memtoReg = 1'b1; e.regWrite = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic void model_step();
        if (!reset) begin
            m_phase = 0; m_wait = 0; m_drop = 1'b0; m_instr = '0; m_cycles = '0;
            return;
        end
        m_cycles = m_cycles + 32'd1;
        if (m_phase == 0 && m_drop) begin
            m_drop = 1'b0;
            return;
        end
        if (mem_phase() && !mem_ready) begin
            if (tmo_hit()) begin m_wait = 0; m_phase = 0; m_drop = 1'b1; end
            else m_wait++;
            return;
        end
        m_wait = 0;
        if (m_phase == 1) m_cls = classify(op, funct);
        if (m_phase != 0 && m_phase == post_len(m_cls)) begin
            if (m_cls != C_ILL) m_instr = m_instr + 32'd1;
            m_phase = 0;
        end else begin
            m_phase++;
        end
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = 6'h00; funct = 6'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, obs); end
`ifdef MIPS_CTRL_PERF_EN
            n_tests++;
            if (i > 0 && cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_cycle_count got=%0d exp=0", cycle_count); end
`endif
            model_step();
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        exp_v = model_out();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, exp_v); end
        n_tests++;
        if ({mem_req, iord} !== 2'b10) begin n_fail++; $display("FAIL reset_fetch mem_req/iord got=%b exp=10", {mem_req, iord}); end
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        apply_reset();
        op = 6'h00; funct = 6'h20; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_v = model_out();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL rtype cyc=%0d got=%h exp=%h", i, obs, exp_v); end
            n_tests++;
            if ((i == 0 && {irwrite, pc_en} !== 2'b11) || (i == 2 && {aluControl, alusrca} !== 5'b00101) ||
                (i == 3 && {regdst, regWrite} !== 2'b11) || (i == 4 && mem_req !== 1'b1)) begin
                n_fail++; $display("FAIL rtype_step cyc=%0d got=%h", i, obs);
            end
            model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        apply_reset();
        op = 6'h23; funct = 6'h00;
        for (int i = 0; i < 9; i++) begin
            mem_ready = !(i >= 3 && i <= 5);
            @(negedge clk);
            exp_v = model_out();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL lw_wait cyc=%0d got=%h exp=%h", i, obs, exp_v); end
            n_tests++;
            if ((i >= 3 && i <= 6 && {mem_req, iord} !== 2'b11) || (i == 7 && {memtoReg, regWrite} !== 2'b11) ||
                (i == 8 && {mem_req, iord} !== 2'b10)) begin
                n_fail++; $display("FAIL lw_step cyc=%0d got=%h", i, obs);
            end
            model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        for (int z = 0; z < 2; z++) begin
            apply_reset();
            op = 6'h04; funct = 6'h00; mem_ready = 1'b1; zero = z[0];
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                exp_v = model_out();
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL beq z=%0d cyc=%0d got=%h exp=%h", z, i, obs, exp_v); end
                n_tests++;
                if ((i == 2 && {pc_en, pcsrc} !== {z[0], 2'b01}) || (i == 3 && mem_req !== 1'b1)) begin
                    n_fail++; $display("FAIL beq_pc z=%0d cyc=%0d got=%b", z, i, {pc_en, pcsrc});
                end
                model_step();
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        op = 6'h00; funct = 6'h20; zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = (i >= 5);
            @(negedge clk);
            exp_v = model_out();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs, exp_v); end
            n_tests++;
            if ((i < 5 && irwrite !== 1'b0) || (i < 3 && mem_err !== 1'b0) || (i == 3 && mem_err !== 1'b1) ||
                (i == 4 && {mem_req, mem_err} !== 2'b00) || (i == 5 && {mem_req, irwrite} !== 2'b11)) begin
                n_fail++; $display("FAIL timeout_step cyc=%0d got=%h", i, obs);
            end
            model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [2];
        logic [5:0]  fns [2];
        logic [31:0] snap;
        ops = '{6'h3F, 6'h00};
        fns = '{6'h00, 6'h21};
        snap = '0;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            op = ops[k]; funct = fns[k]; mem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
`ifdef MIPS_CTRL_PERF_EN
                if (i == 0) snap = instr_count;
`endif
                exp_v = model_out();
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL illegal k=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_v); end
                n_tests++;
                if ({regWrite, memwrite} !== 2'b00 || illegal_op !== (i == 1) || (i == 2 && mem_req !== 1'b1)) begin
                    n_fail++; $display("FAIL illegal_step k=%0d cyc=%0d got=%h", k, i, obs);
                end
                model_step();
                @(posedge clk); #1;
            end
`ifdef MIPS_CTRL_PERF_EN
            @(negedge clk);
            n_tests++;
            if (instr_count !== snap) begin n_fail++; $display("FAIL illegal_instr_count got=%0d exp=%0d", instr_count, snap); end
            @(posedge clk); #1;
            model_step();
`endif
        end
    endtask

    task automatic test_random();
        logic [5:0] rf [5];
        rf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 299) != 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            zero      = 1'($urandom_range(0, 1));
            if (m_phase == 0) begin
                case ($urandom_range(0, 7))
                    0: begin op = 6'h00; funct = rf[$urandom_range(0, 4)]; end
                    1: op = 6'h23;
                    2: op = 6'h2B;
                    3: op = 6'h04;
                    4: op = 6'h08;
                    5: op = 6'h02;
                    6: op = 6'($urandom_range(0, 63));
                    default: begin op = 6'h00; funct = 6'($urandom_range(0, 63)); end
                endcase
            end
            @(negedge clk);
            exp_v = model_out();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d op=%h fn=%h got=%h exp=%h", c, op, funct, obs, exp_v); end
`ifdef MIPS_CTRL_PERF_EN
            n_tests++;
            if (instr_count !== m_instr || cycle_count !== m_cycles) begin
                n_fail++; $display("FAIL random_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", c, instr_count, cycle_count, m_instr, m_cycles);
            end
`endif
            model_step();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_timeout();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
